// File: rtl/ft2232h_fifo_model_pkg.sv
// Shared constants for the FT2232H 245-FIFO device model: byte width,
// default recovery time and the 2-bit handshake FSM encoding.
package ft2232h_pkg;
    localparam int BYTE_W           = 8;
    localparam int RECOVERY_DEFAULT = 2;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RECOV = 2'd3;
endpackage

// File: rtl/ft2232h_fifo_model_if.sv
// Bundle of the 245-FIFO bus pins plus the host-side byte ports.
// master = controller/host driver, slave = the device model.
interface ft2232h_fifo_model_if;
    import ft2232h_pkg::*;

    logic  USB_RDn;
    logic  USB_WRn;
    logic  USB_DEN;
    byte_t USB_DOUT;
    byte_t USB_DIN;
    logic  USB_RXFn;
    logic  USB_TXEn;
    byte_t H_WDATA;
    logic  H_WE;
    logic  H_FULL;
    byte_t H_RDATA;
    logic  H_RE;
    logic  H_EMPTY;
    logic  PROTO_ERR;

    modport master (
        output USB_RDn, USB_WRn, USB_DEN, USB_DOUT, H_WDATA, H_WE, H_RE,
        input  USB_DIN, USB_RXFn, USB_TXEn, H_FULL, H_RDATA, H_EMPTY, PROTO_ERR
    );

    modport slave (
        input  USB_RDn, USB_WRn, USB_DEN, USB_DOUT, H_WDATA, H_WE, H_RE,
        output USB_DIN, USB_RXFn, USB_TXEn, H_FULL, H_RDATA, H_EMPTY, PROTO_ERR
    );
endinterface

// File: rtl/ft2232h_fifo_model_byte_sync_fifo.sv
// Single-clock byte FIFO with first-word fall-through read. Pointers carry
// one extra wrap bit so full/empty need no separate counter.
module byte_sync_fifo
    import ft2232h_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic  CLK,
    input  logic  RSTn,
    input  byte_t wdata,
    input  logic  we,
    output byte_t rdata,
    input  logic  re,
    output logic  full,
    output logic  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    byte_t                 mem [DEPTH];
    logic [DEPTH_LOG2:0]   wptr_q;
    logic [DEPTH_LOG2:0]   rptr_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                     (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
    assign do_push = we && !full;
    assign do_pop  = re && !empty;

    // Head is forced to zero when empty so stale RAM never leaks out.
    assign rdata   = empty ? '0 : mem[rptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr_q[DEPTH_LOG2-1:0]] <= wdata;
    end
endmodule

// File: rtl/ft2232h_fifo_model.sv
// Device-side responder for the FT2232H asynchronous 245-FIFO bus: two host
// byte FIFOs, RD#/WR# handshake FSM with recovery time, sticky error flag.
module ft2232h_fifo_model
    import ft2232h_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int RECOVERY   = RECOVERY_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    ft2232h_fifo_model_if.slave   bus
);
    localparam logic [3:0] RECOV_CNT = 4'(RECOVERY);

    logic       rdn_q, wrn_q;
    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    byte_t      din_q, din_d;
    logic       rxfn_q, rxfn_d;
    logic       txen_q, txen_d;
    logic       err_q, err_d;

    logic       rd_start, wr_start;
    logic       rx_pop, tx_push;
    logic       rx_empty, tx_full;
    byte_t      rx_rdata;

    byte_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .wdata (bus.H_WDATA),
        .we    (bus.H_WE),
        .rdata (rx_rdata),
        .re    (rx_pop),
        .full  (bus.H_FULL),
        .empty (rx_empty)
    );

    byte_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .wdata (bus.USB_DOUT),
        .we    (tx_push),
        .rdata (bus.H_RDATA),
        .re    (bus.H_RE),
        .full  (tx_full),
        .empty (bus.H_EMPTY)
    );

    assign rd_start = !bus.USB_RDn && rdn_q;
    assign wr_start = !bus.USB_WRn && wrn_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        err_d   = err_q;
        rx_pop  = 1'b0;
        tx_push = 1'b0;
        if (bus.USB_DEN && !bus.USB_RDn) err_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                // A read start under contention is refused like any other violation.
                if (rd_start && wr_start) begin
                    err_d = 1'b1;
                end else if (rd_start) begin
                    if (rx_empty || bus.USB_DEN) begin
                        err_d = 1'b1;
                    end else begin
                        rx_pop  = 1'b1;
                        din_d   = rx_rdata;
                        state_d = ST_READ;
                    end
                end else if (wr_start) begin
                    if (tx_full || !bus.USB_DEN) begin
                        err_d = 1'b1;
                    end else begin
                        tx_push = 1'b1;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (bus.USB_RDn) begin
                    state_d = ST_RECOV;
                    cnt_d   = RECOV_CNT;
                end
            end
            ST_WRITE: begin
                if (bus.USB_WRn) begin
                    state_d = ST_RECOV;
                    cnt_d   = RECOV_CNT;
                end
            end
            default: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
        // Flags follow the next state so they rise on the same edge a transfer starts.
        rxfn_d = !((state_d == ST_IDLE) && !rx_empty);
        txen_d = !((state_d == ST_IDLE) && !tx_full);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            din_q   <= '0;
            rxfn_q  <= 1'b1;
            txen_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            rdn_q   <= bus.USB_RDn;
            wrn_q   <= bus.USB_WRn;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            rxfn_q  <= rxfn_d;
            txen_q  <= txen_d;
            err_q   <= err_d;
        end
    end

    assign bus.USB_DIN   = din_q;
    assign bus.USB_RXFn  = rxfn_q;
    assign bus.USB_TXEn  = txen_q;
    assign bus.PROTO_ERR = err_q;
endmodule

// File: tb/tb_ft2232h_fifo_model.sv
// Randomised bench for ft2232h_fifo_model against a queue-based model of the
// two host FIFOs, the recovery timing and the sticky error flag.
module tb_ft2232h_fifo_model;
    localparam int R     = 2;
    localparam int DEPTH = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    ft2232h_fifo_model_if bus ();

    ft2232h_fifo_model #(.DEPTH_LOG2(4), .RECOVERY(R)) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_m[$];
    logic [7:0] tx_m[$];
    logic [7:0] din_m;
    logic       err_m;

    function automatic logic [31:0] b2w(input logic b);
        return {31'b0, b};
    endfunction

    function automatic logic [31:0] y2w(input logic [7:0] y);
        return {24'b0, y};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " din"},    y2w(bus.USB_DIN), 32'h0);
        check({tag, " rxfn"},   b2w(bus.USB_RXFn), 32'h1);
        check({tag, " txen"},   b2w(bus.USB_TXEn), 32'h1);
        check({tag, " err"},    b2w(bus.PROTO_ERR), 32'h0);
        check({tag, " hfull"},  b2w(bus.H_FULL), 32'h0);
        check({tag, " hempty"}, b2w(bus.H_EMPTY), 32'h1);
        check({tag, " hrdata"}, y2w(bus.H_RDATA), 32'h0);
    endtask

    task automatic idle_inputs();
        bus.USB_RDn  = 1'b1;
        bus.USB_WRn  = 1'b1;
        bus.USB_DEN  = 1'b0;
        bus.USB_DOUT = 8'h00;
        bus.H_WDATA  = 8'h00;
        bus.H_WE     = 1'b0;
        bus.H_RE     = 1'b0;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset");
        rx_m.delete();
        tx_m.delete();
        din_m = 8'h00;
        err_m = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        $display("reset applied");
    endtask

    task automatic host_push(input logic [7:0] b);
        check("host_push hfull", b2w(bus.H_FULL), b2w(rx_m.size() == DEPTH));
        bus.H_WDATA = b;
        bus.H_WE    = 1'b1;
        @(negedge clk);
        bus.H_WE = 1'b0;
        if (rx_m.size() < DEPTH) rx_m.push_back(b);
        @(negedge clk);
        $display("host push %02h rx_count=%0d", b, rx_m.size());
    endtask

    task automatic host_pop();
        check("host_pop hempty", b2w(bus.H_EMPTY), b2w(tx_m.size() == 0));
        if (tx_m.size() > 0) check("host_pop hrdata", y2w(bus.H_RDATA), y2w(tx_m[0]));
        bus.H_RE = 1'b1;
        @(negedge clk);
        bus.H_RE = 1'b0;
        if (tx_m.size() > 0) void'(tx_m.pop_front());
        @(negedge clk);
        $display("host pop tx_count=%0d", tx_m.size());
    endtask

    // After a strobe is released both flags stay high for exactly R cycles.
    task automatic recov_check(input string tag);
        for (int i = 0; i < R; i++) begin
            @(negedge clk);
            check({tag, " recov rxfn"}, b2w(bus.USB_RXFn), 32'h1);
            check({tag, " recov txen"}, b2w(bus.USB_TXEn), 32'h1);
        end
        @(negedge clk);
        check({tag, " idle rxfn"}, b2w(bus.USB_RXFn), b2w(rx_m.size() == 0));
        check({tag, " idle txen"}, b2w(bus.USB_TXEn), b2w(tx_m.size() == DEPTH));
    endtask

    task automatic usb_read(input int hold, input bit push_too, input logic [7:0] pb, input bit contend);
        bit was_full;
        check("rd start rxfn", b2w(bus.USB_RXFn), b2w(rx_m.size() == 0));
        was_full    = (rx_m.size() == DEPTH);
        bus.USB_RDn = 1'b0;
        if (push_too) begin
            bus.H_WDATA = pb;
            bus.H_WE    = 1'b1;
        end
        @(negedge clk);
        bus.H_WE = 1'b0;
        if (rx_m.size() == 0) begin
            err_m = 1'b1;
            check("rd empty din",  y2w(bus.USB_DIN), y2w(din_m));
            check("rd empty err",  b2w(bus.PROTO_ERR), b2w(err_m));
            check("rd empty txen", b2w(bus.USB_TXEn), b2w(tx_m.size() == DEPTH));
            bus.USB_RDn = 1'b1;
            @(negedge clk);
            $display("usb read on empty fifo refused");
        end else begin
            din_m = rx_m.pop_front();
            if (push_too && !was_full) rx_m.push_back(pb);
            check("rd din",  y2w(bus.USB_DIN), y2w(din_m));
            check("rd rxfn", b2w(bus.USB_RXFn), 32'h1);
            check("rd txen", b2w(bus.USB_TXEn), 32'h1);
            for (int i = 1; i < hold; i++) begin
                if (contend) begin
                    bus.USB_DEN = 1'b1;
                    err_m = 1'b1;
                end
                @(negedge clk);
                check("rd din hold", y2w(bus.USB_DIN), y2w(din_m));
            end
            bus.USB_RDn = 1'b1;
            bus.USB_DEN = 1'b0;
            recov_check("rd");
            check("rd err", b2w(bus.PROTO_ERR), b2w(err_m));
            $display("usb read %02h hold=%0d contend=%0d rx_count=%0d", din_m, hold, contend, rx_m.size());
        end
    endtask

    task automatic usb_write(input logic [7:0] b, input int hold, input bit den);
        check("wr start txen", b2w(bus.USB_TXEn), b2w(tx_m.size() == DEPTH));
        bus.USB_DOUT = b;
        bus.USB_DEN  = den;
        bus.USB_WRn  = 1'b0;
        @(negedge clk);
        if (tx_m.size() == DEPTH || !den) begin
            err_m = 1'b1;
            check("wr refused err",  b2w(bus.PROTO_ERR), b2w(err_m));
            check("wr refused rxfn", b2w(bus.USB_RXFn), b2w(rx_m.size() == 0));
            check("wr refused txen", b2w(bus.USB_TXEn), b2w(tx_m.size() == DEPTH));
            bus.USB_WRn = 1'b1;
            bus.USB_DEN = 1'b0;
            @(negedge clk);
            $display("usb write %02h refused den=%0d", b, den);
        end else begin
            tx_m.push_back(b);
            check("wr txen", b2w(bus.USB_TXEn), 32'h1);
            check("wr rxfn", b2w(bus.USB_RXFn), 32'h1);
            for (int i = 1; i < hold; i++) begin
                @(negedge clk);
                check("wr txen hold", b2w(bus.USB_TXEn), 32'h1);
            end
            bus.USB_WRn = 1'b1;
            bus.USB_DEN = 1'b0;
            recov_check("wr");
            check("wr err", b2w(bus.PROTO_ERR), b2w(err_m));
            $display("usb write %02h hold=%0d tx_count=%0d", b, hold, tx_m.size());
        end
    endtask

    task automatic both_start();
        bus.USB_RDn = 1'b0;
        bus.USB_WRn = 1'b0;
        @(negedge clk);
        err_m = 1'b1;
        check("both err",  b2w(bus.PROTO_ERR), 32'h1);
        check("both rxfn", b2w(bus.USB_RXFn), b2w(rx_m.size() == 0));
        check("both txen", b2w(bus.USB_TXEn), b2w(tx_m.size() == DEPTH));
        check("both din",  y2w(bus.USB_DIN), y2w(din_m));
        bus.USB_RDn = 1'b1;
        bus.USB_WRn = 1'b1;
        @(negedge clk);
        $display("simultaneous read and write start refused");
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);

        // Two host bytes read back in order, flag latency of one cycle.
        reset_dut();
        bus.H_WDATA = 8'hA5;
        bus.H_WE    = 1'b1;
        @(negedge clk);
        bus.H_WE = 1'b0;
        rx_m.push_back(8'hA5);
        check("push rxfn lag", b2w(bus.USB_RXFn), 32'h1);
        @(negedge clk);
        check("push rxfn low", b2w(bus.USB_RXFn), 32'h0);
        host_push(8'h3C);
        usb_read(2, 1'b0, 8'h00, 1'b0);
        usb_read(2, 1'b0, 8'h00, 1'b0);
        check("t1 hfull", b2w(bus.H_FULL), 32'h0);
        check("t1 err",   b2w(bus.PROTO_ERR), 32'h0);

        // Fill the TX FIFO, overflow write, drain from the host.
        reset_dut();
        for (int i = 1; i <= DEPTH; i++) usb_write(8'(i), 1, 1'b1);
        usb_write(8'h11, 1, 1'b1);
        check("t2 err", b2w(bus.PROTO_ERR), 32'h1);
        for (int i = 0; i < DEPTH; i++) host_pop();
        check("t2 hempty", b2w(bus.H_EMPTY), 32'h1);

        // Read on an empty RX FIFO.
        reset_dut();
        usb_read(1, 1'b0, 8'h00, 1'b0);
        check("t3 err", b2w(bus.PROTO_ERR), 32'h1);

        // Long WR# pulse stores a single byte.
        reset_dut();
        usb_write(8'h77, 5, 1'b1);
        host_pop();
        check("t4 hempty", b2w(bus.H_EMPTY), 32'h1);

        // Near-full RX FIFO with simultaneous push/pop across the pointer wrap.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            host_push(8'($urandom));
            usb_read(1, 1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < DEPTH - 1; i++) host_push(8'($urandom));
        usb_read(2, 1'b1, 8'hEE, 1'b0);
        check("t5 count15 hfull", b2w(bus.H_FULL), 32'h0);
        host_push(8'h5D);
        host_push(8'h99);
        for (int i = 0; i < DEPTH; i++) usb_read(1, 1'b0, 8'h00, 1'b0);
        check("t5 err", b2w(bus.PROTO_ERR), 32'h0);

        // Asynchronous reset in the middle of a read.
        reset_dut();
        host_push(8'h5A);
        bus.USB_RDn = 1'b0;
        @(negedge clk);
        check("t6 din before reset", y2w(bus.USB_DIN), 32'h5A);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("t6 async");
        rx_m.delete();
        din_m = 8'h00;
        bus.USB_RDn = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6 rxfn", b2w(bus.USB_RXFn), 32'h1);
        check("t6 hfull", b2w(bus.H_FULL), 32'h0);
        check("t6 din", y2w(bus.USB_DIN), 32'h0);

        // Random traffic with occasional protocol violations.
        reset_dut();
        for (int n = 0; n < 300; n++) begin
            int hold;
            hold = int'($urandom_range(1, 3));
            case ($urandom_range(0, 9))
                0, 1, 2: host_push(8'($urandom));
                3, 4:    host_pop();
                5, 6: begin
                    if (rx_m.size() > 0 || $urandom_range(0, 9) == 0)
                        usb_read(hold, 1'b0, 8'h00, (hold >= 2) && ($urandom_range(0, 14) == 0));
                    else
                        host_push(8'($urandom));
                end
                7, 8:    usb_write(8'($urandom), hold, $urandom_range(0, 11) != 0);
                default: begin
                    if ($urandom_range(0, 7) == 0) both_start();
                    else host_pop();
                end
            endcase
        end
        check("final err", b2w(bus.PROTO_ERR), b2w(err_m));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ft2232h_fifo_model.md
Name: ft2232h_fifo_model

Overview:
- Synthesizable device-side responder for the FT2232H asynchronous 245-FIFO bus.
- Drives RXF#/TXE# and the read data bus, and responds to RD#/WR#/DEN from the FPGA-side USB interface controller.
- Host side has two byte FIFOs: host-to-FPGA (RX path) and FPGA-to-host (TX path).
- Used for on-chip loopback, bring-up without a PC, and as the checked DUT-partner in controller benches.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries).
- RECOVERY, 2, cycles RXF#/TXE# stay high after RD#/WR# deassert; legal range 1-15.

Ports:
- CLK  input  1  interface clock, shared with the controller.
- RSTn  input  1  asynchronous active-low reset.
- USB_RDn  input  1  read strobe from controller, active low.
- USB_WRn  input  1  write strobe from controller, active low.
- USB_DEN  input  1  controller data-bus output enable.
- USB_DOUT  input  8  controller write data.
- USB_DIN  output  8  read data to controller.
- USB_RXFn  output  1  low = RX data available.
- USB_TXEn  output  1  low = TX space available.
- H_WDATA  input  8  host byte to send to FPGA.
- H_WE  input  1  push H_WDATA into RX FIFO.
- H_FULL  output  1  RX FIFO full.
- H_RDATA  output  8  head of TX FIFO (first-word fall-through).
- H_RE  input  1  pop TX FIFO.
- H_EMPTY  output  1  TX FIFO empty.
- PROTO_ERR  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, RSTn=0):
  - Both FIFOs empty; USB_DIN=8'h00; USB_RXFn=1; USB_TXEn=1; PROTO_ERR=0; H_FULL=0; H_EMPTY=1; H_RDATA=8'h00; FSM in IDLE; recovery counter 0.
  - Reset mid-transfer discards any in-flight byte.
- Strobes are sampled at posedge into rdn_q and wrn_q (reset value 1).
  - Read start: USB_RDn=0 && rdn_q=1.
  - Write start: USB_WRn=0 && wrn_q=1.
- FSM states: IDLE, READ, WRITE, RECOV.
  - IDLE -> READ on read start with RX FIFO non-empty:
    - Pop head into USB_DIN register; new value is visible the cycle after RD# is first seen low.
    - The controller samples it on the second edge after asserting RD#; latency 1 is mandatory.
  - READ: hold USB_DIN; on USB_RDn=1 go to RECOV with counter=RECOVERY.
  - IDLE -> WRITE on write start with TX FIFO not full:
    - Capture USB_DOUT into TX FIFO in the same cycle.
    - Exactly one byte per WR# low pulse, regardless of pulse length.
  - WRITE: on USB_WRn=1 go to RECOV with counter=RECOVERY.
  - RECOV: decrement each cycle; at 1 go to IDLE.
- Flag outputs, registered:
  - USB_RXFn=0 only in IDLE with RX FIFO non-empty.
  - USB_TXEn=0 only in IDLE with TX FIFO not full.
  - Both are high in READ, WRITE and RECOV.
- PROTO_ERR is set, and the offending strobe ignored (no pop/push, FSM stays IDLE), when:
  - a read start occurs while the RX FIFO is empty;
  - a write start occurs while the TX FIFO is full;
  - a write start occurs with USB_DEN=0;
  - a read start and a write start occur in the same cycle (neither is serviced);
  - USB_DEN=1 is sampled while USB_RDn=0 (bus contention).
- PROTO_ERR clears only on reset.
- Host side:
  - H_WE while H_FULL: write dropped.
  - H_RE while H_EMPTY: ignored.
  - Simultaneous host push and USB pop on the RX FIFO in one cycle are both honoured; count unchanged.
  - Same rule for USB push and host pop on the TX FIFO.
- FIFO pointers are DEPTH_LOG2+1 bits with natural wrap; full = MSBs differ and LSBs equal.

Decomposition:
- Package ft2232h_pkg: FSM state encoding (2-bit), byte-width constant 8, default RECOVERY.
- One sub-module, byte_sync_fifo (params DEPTH_LOG2; ports CLK, RSTn, wdata, we, rdata, re, full, empty, fall-through read), instantiated twice.

Test Plan:
- Host pushes 8'hA5, 8'h3C; controller issues two reads -> USB_RXFn falls 1 cycle after push; USB_DIN=A5 then 3C; RXF# high ≥RECOVERY cycles between reads; H_FULL=0; PROTO_ERR=0.
- Controller writes 8'h01..8'h10 (16 bytes) -> TX FIFO full, USB_TXEn stays 1; 17th WR# pulse sets PROTO_ERR; host pops 01..10 in order, then H_EMPTY=1.
- RD# asserted with RX FIFO empty -> USB_DIN unchanged, no pop, PROTO_ERR=1, FSM stays IDLE.
- WR# held low 5 cycles with USB_DOUT=8'h77, DEN=1 -> exactly one 77 entry in TX FIFO; TXE# low again RECOVERY cycles after WR# rises.
- Fill the RX FIFO to 15 entries, then host push and USB read in the same cycle -> count stays 15; data order preserved across pointer wrap.
- RSTn pulsed low during READ -> all outputs at reset values asynchronously; the byte being read is discarded; FIFO empty on release.
